// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin/fixed-priority common data bus arbiter with registered broadcast
module cdb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               rr_en,
  input  logic [3:0]         require,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  data3,
  input  logic [LABEL_W-1:0] label0,
  input  logic [LABEL_W-1:0] label1,
  input  logic [LABEL_W-1:0] label2,
  input  logic [LABEL_W-1:0] label3,
  output logic [3:0]         accept,
  output logic               BCEN,
  output logic [DATA_W-1:0]  BCdata,
  output logic [LABEL_W-1:0] BClabel,
  output logic               bad_label,
  output logic [1:0]         ptr
);
  logic [1:0] sel, cand;
  logic hit;
  logic [DATA_W-1:0] sel_data;
  logic [LABEL_W-1:0] sel_label;
  always_comb begin
    sel = 2'd0;
    cand = 2'd0;
    hit = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_en ? ptr + 2'(k) : 2'(k);
      if (require[cand]) begin
        sel = cand;
        hit = 1'b1;
      end
    end
  end
  assign accept    = hit ? 4'b0001 << sel : 4'b0000;
  assign sel_data  = sel[1] ? (sel[0] ? data3 : data2) : (sel[0] ? data1 : data0);
  assign sel_label = sel[1] ? (sel[0] ? label3 : label2) : (sel[0] ? label1 : label0);
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr       <= 2'd0;
      BCEN      <= 1'b0;
      BCdata    <= '0;
      BClabel   <= '0;
      bad_label <= 1'b0;
    end else begin
      if (hit && rr_en) ptr <= sel + 2'd1;
      BCEN <= hit && |sel_label;
      if (hit && |sel_label) begin
        BCdata  <= sel_data;
        BClabel <= sel_label;
      end
      if (hit && ~|sel_label) bad_label <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter grants and broadcasts
module tb_cdb_arbiter;
  typedef struct packed {
    logic        en;
    logic [31:0] d;
    logic [3:0]  l;
  } bc_t;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic rr_en = 1'b1;
  logic [3:0] require = 4'b0000;
  logic [31:0] d [4];
  logic [3:0] l [4];
  logic [3:0] accept;
  logic BCEN, bad_label;
  logic [31:0] BCdata;
  logic [3:0] BClabel;
  logic [1:0] ptr;
  bc_t sb [$];
  int checks = 0;
  int errors = 0;
  logic [1:0] mp = 2'd0;
  logic [31:0] last_d = '0;
  logic [3:0] last_l = '0;
  logic exp_bad = 1'b0;
  always #5 clk = ~clk;
  cdb_arbiter #(.DATA_W(32), .LABEL_W(4)) dut (
    .clk(clk), .nRST(nRST), .rr_en(rr_en), .require(require),
    .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
    .label0(l[0]), .label1(l[1]), .label2(l[2]), .label3(l[3]),
    .accept(accept), .BCEN(BCEN), .BCdata(BCdata), .BClabel(BClabel),
    .bad_label(bad_label), .ptr(ptr)
  );
  // Monitor: each entry pushed in cycle t is the expected broadcast after edge t+1
  always @(posedge clk) begin
    bc_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({BCEN, BCdata, BClabel} !== e) begin
        errors++;
        $display("FAIL broadcast: got en=%b data=%h label=%h expected en=%b data=%h label=%h",
                 BCEN, BCdata, BClabel, e.en, e.d, e.l);
      end
    end
  end
  task automatic push_exp(input logic [3:0] acc);
    int w = -1;
    for (int i = 0; i < 4; i++) if (acc[i]) w = i;
    if (w < 0) sb.push_back({1'b0, last_d, last_l});
    else begin
      if (rr_en) mp = 2'(w + 1);
      if (l[w] != 4'd0) begin
        last_d = d[w];
        last_l = l[w];
        sb.push_back({1'b1, last_d, last_l});
      end else begin
        exp_bad = 1'b1;
        sb.push_back({1'b0, last_d, last_l});
      end
    end
  endtask
  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      d[i] = 32'h1000 + i;
      l[i] = 4'(i + 1);
    end
    require = 4'b1111;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({BCEN, BCdata, BClabel, ptr, bad_label} !== '0) begin
      errors++;
      $display("FAIL reset_state: got en=%b data=%h label=%h ptr=%0d bad=%b expected all zero",
               BCEN, BCdata, BClabel, ptr, bad_label);
    end
    nRST = 1'b1;
    #1;
    checks++;
    if (accept !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 0001", accept);
    end
    push_exp(4'b0001);
  endtask
  task automatic test_single;
    @(posedge clk); #2;
    d[1] = 32'h0000_00AB;
    l[1] = 4'h5;
    require = 4'b0010;
    #1;
    checks++;
    if (accept !== 4'b0010) begin
      errors++;
      $display("FAIL single_accept: got %b expected 0010", accept);
    end
    push_exp(4'b0010);
    @(posedge clk); #2;
    require = 4'b0000;
    checks++;
    if (ptr !== 2'd2) begin
      errors++;
      $display("FAIL single_ptr: got %0d expected 2", ptr);
    end
    #1;
    checks++;
    if (accept !== 4'b0000) begin
      errors++;
      $display("FAIL idle_accept: got %b expected 0000", accept);
    end
    push_exp(4'b0000);
  endtask
  task automatic test_rr;
    @(posedge clk); #2;
    nRST = 1'b0;
    mp = 2'd0; last_d = '0; last_l = '0; exp_bad = 1'b0;
    #1 nRST = 1'b1;
    rr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #2;
      end
      for (int i = 0; i < 4; i++) begin
        d[i] = $urandom;
        l[i] = 4'(4 * (k % 2) + i + 1);
      end
      require = 4'b1111;
      checks++;
      if (ptr !== 2'(k % 4)) begin
        errors++;
        $display("FAIL rr_ptr[%0d]: got %0d expected %0d", k, ptr, k % 4);
      end
      #1;
      checks++;
      if (accept !== 4'b0001 << (k % 4)) begin
        errors++;
        $display("FAIL rr_accept[%0d]: got %b expected %b", k, accept, 4'b0001 << (k % 4));
      end
      push_exp(4'b0001 << (k % 4));
    end
  endtask
  task automatic test_fixed;
    @(posedge clk); #2;
    rr_en = 1'b0;
    require = 4'b1100;
    #1;
    checks++;
    if (accept !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_1100: got %b expected 0100", accept);
    end
    push_exp(4'b0100);
    @(posedge clk); #2;
    require = 4'b1101;
    #1;
    checks++;
    if (accept !== 4'b0001) begin
      errors++;
      $display("FAIL fixed_1101: got %b expected 0001", accept);
    end
    push_exp(4'b0001);
    @(posedge clk); #2;
    require = 4'b0000;
    checks++;
    if (ptr !== mp) begin
      errors++;
      $display("FAIL fixed_ptr_hold: got %0d expected %0d", ptr, mp);
    end
    push_exp(4'b0000);
  endtask
  task automatic test_label_zero;
    @(posedge clk); #2;
    rr_en = 1'b1;
    l[2] = 4'd0;
    d[2] = 32'hDEAD_0002;
    require = 4'b0100;
    #1;
    checks++;
    if (accept !== 4'b0100) begin
      errors++;
      $display("FAIL lz_accept: got %b expected 0100", accept);
    end
    push_exp(4'b0100);
    @(posedge clk); #2;
    checks++;
    if (bad_label !== 1'b1) begin
      errors++;
      $display("FAIL lz_bad_set: got %b expected 1", bad_label);
    end
    l[2] = 4'd7;
    d[2] = 32'hBEEF_0002;
    #1;
    push_exp(4'b0100);
    @(posedge clk); #2;
    require = 4'b0000;
    push_exp(4'b0000);
    checks++;
    if (bad_label !== 1'b1) begin
      errors++;
      $display("FAIL lz_bad_sticky: got %b expected 1", bad_label);
    end
  endtask
  task automatic test_back_to_back;
    for (int k = 0; k < 40; k++) begin
      logic [3:0] exp;
      @(posedge clk); #2;
      rr_en = ($urandom_range(0, 3) != 0);
      require = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        d[i] = $urandom;
        l[i] = 4'($urandom_range(0, 15));
      end
      checks++;
      if (ptr !== mp) begin
        errors++;
        $display("FAIL b2b_ptr[%0d]: got %0d expected %0d", k, ptr, mp);
      end
      exp = 4'b0000;
      for (int j = 0; j < 4; j++) begin
        int c = rr_en ? (int'(mp) + j) % 4 : j;
        if (exp == 4'b0000 && require[c]) exp = 4'b0001 << c;
      end
      #1;
      checks++;
      if (accept !== exp) begin
        errors++;
        $display("FAIL b2b_accept[%0d]: got %b expected %b (req=%b rr=%b)", k, accept, exp, require, rr_en);
      end
      push_exp(exp);
    end
    @(posedge clk); #2;
    require = 4'b0000;
    checks++;
    if (bad_label !== exp_bad) begin
      errors++;
      $display("FAIL b2b_bad_label: got %b expected %b", bad_label, exp_bad);
    end
  endtask
  task automatic test_reset_mid;
    @(posedge clk); #2;
    rr_en = 1'b1;
    d[3] = 32'h3333_CAFE;
    l[3] = 4'h9;
    require = 4'b1000;
    #1;
    checks++;
    if (accept !== 4'b1000) begin
      errors++;
      $display("FAIL rm_accept: got %b expected 1000", accept);
    end
    push_exp(4'b1000);
    @(posedge clk); #3;
    nRST = 1'b0;
    #1;
    checks++;
    if ({BCEN, ptr, bad_label, BCdata, BClabel} !== '0) begin
      errors++;
      $display("FAIL rm_async_clear: got en=%b ptr=%0d bad=%b data=%h label=%h expected all zero",
               BCEN, ptr, bad_label, BCdata, BClabel);
    end
    require = 4'b0000;
    mp = 2'd0; last_d = '0; last_l = '0; exp_bad = 1'b0;
    #2 nRST = 1'b1;
  endtask
  initial begin
    test_reset;
    test_single;
    test_rr;
    test_fixed;
    test_label_zero;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Sequential arbiter for the Tomasulo common data bus (CDB). It selects one result per cycle from the four functional-unit sources: alu, mul, div and load/store. It returns a one-hot accept to the winner and drives a registered broadcast (`BCEN`/`BCdata`/`BClabel`) to the register file and all reservation stations. It sits between the functional-unit state machines and the broadcast consumers, and it owns bus fairness.

## Interface
- `DATA_W`, 32, broadcast data width
- `LABEL_W`, 4, reservation-station label width; label 0 means "no label"

Ports:
- `clk`  in  1  system clock, rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `rr_en`  in  1  1 = round-robin, 0 = fixed priority (source 0 highest)
- `require`  in  4  bit i = source i holds a finished result (0 alu, 1 mul, 2 div, 3 load/store)
- `data0`..`data3`  in  DATA_W  result of source i; valid while `require[i]` = 1
- `label0`..`label3`  in  LABEL_W  destination label of source i
- `accept`  out  4  one-hot grant; combinational, same cycle as `require`
- `BCEN`  out  1  broadcast valid, registered
- `BCdata`  out  DATA_W  broadcast data, registered
- `BClabel`  out  LABEL_W  broadcast label, registered
- `bad_label`  out  1  sticky; set when a source was granted with label 0
- `ptr`  out  2  current round-robin start pointer (debug)

## Operation
- Reset values: `ptr` = 0, `BCEN` = 0, `BCdata` = 0, `BClabel` = 0, `bad_label` = 0. `accept` = 0 whenever `require` = 0.
- Selection, round-robin (`rr_en` = 1):
  - Scan order is `ptr`, `ptr`+1, … mod 4.
  - The first set `require` bit wins.
  - `accept` = one-hot of the winner. At most one bit is ever high.
- Selection, fixed priority (`rr_en` = 0): lowest set index wins. `ptr` holds its value.
- Pointer update (rr mode only): on an edge with a grant to source i, `ptr` ← (i+1) mod 4. Wrap 3→0 is required. With no grant, `ptr` holds.
- Broadcast register, on each rising edge:
  - Grant with label ≠ 0: `BCEN` ← 1, `BCdata` ← data_i, `BClabel` ← label_i.
  - Grant with label = 0: the source is still accepted so it can release. `BCEN` ← 0, `bad_label` ← 1. `BCdata` and `BClabel` hold.
  - No grant: `BCEN` ← 0. `BCdata` and `BClabel` hold their last values.
- `bad_label` clears only on reset.
- Requester contract:
  - A source holds `require`, data and label stable until it samples `accept[i]` = 1 at a rising edge.
  - After that edge it deasserts `require[i]` or presents its next result.
  - Data and label changing while `require[i]` = 1 and the source is not yet accepted is a protocol violation. The arbiter is not required to detect it.
- The arbiter does not inspect `BCEN` consumers. The broadcast is fire-and-forget.

## Timing
- Request-to-accept latency: 0 cycles. `accept` is combinational from `require`, `ptr` and `rr_en`.
- Accept-to-broadcast latency: 1 cycle. A winner in cycle t gives `BCEN` = 1 with its data in cycle t+1.
- Throughput: one broadcast per cycle. Back-to-back grants to different sources, or to the same source, are allowed. `BCEN` may stay high for consecutive cycles.
- Simultaneous requests: exactly one winner per cycle. In rr mode, any continuously asserted request is granted within 4 cycles, so there is no starvation.
- A `rr_en` toggle takes effect in the same cycle. On a 1→0 switch, `ptr` freezes at its current value.
- Reset mid-operation: asserting `nRST` low clears all state immediately, including `BCEN` = 0. The pending winner's broadcast is dropped. After release, arbitration restarts from `ptr` = 0.
- No internal multicycle state. The only state elements are `ptr`, the broadcast register and `bad_label`.

## Test plan
- Reset: hold `nRST` = 0 with `require` = 4'b1111 → `BCEN` = 0, `BCdata` = 0, `BClabel` = 0, `ptr` = 0. After release, the first grant is `accept` = 4'b0001.
- Single source: `require` = 4'b0010, `data1` = 32'h0000_00AB, `label1` = 4'h5 → `accept` = 4'b0010 in the same cycle. Next cycle: `BCEN` = 1, `BCdata` = 32'hAB, `BClabel` = 5, `ptr` = 2.
- Round-robin fairness: `require` = 4'b1111 held for 8 cycles, `rr_en` = 1 → grants 0,1,2,3,0,1,2,3. `BCEN` is high for 8 consecutive cycles with matching labels. `ptr` wraps 3→0.
- Fixed priority: `rr_en` = 0, `require` = 4'b1100 then 4'b1101 → grants 2, then 0. `ptr` is unchanged throughout.
- Label zero: `require` = 4'b0100, `label2` = 0 → `accept` = 4'b0100. Next cycle: `BCEN` = 0 and `bad_label` = 1. `bad_label` stays 1 after later legal grants.
- Reset during broadcast: grant source 3 at cycle t, then pull `nRST` low mid-cycle t+1 → `BCEN` drops to 0 asynchronously and `ptr` = 0.
